bp_l2_dma_mux: RTL
==================

// Module: bp_l2_dma_mux
// PURPOSE
//  Sits directly downstream of the L2 cache slice DMA ports: merges l2_banks_p bsg_cache DMA
//  channels (pkt, write-data, read-data) onto one DRAM-side DMA channel. Round-robin packet
//  arbitration; in-order per-channel tag FIFOs steer write-data and read-data bursts.
//  Lets a multi-bank unicore drive a single-port memory controller.
// PARAMETERS
//  banks_p        2    number of L2 bank DMA channels (>=1)
//  daddr_width_p  32   DRAM address width; pkt width = daddr_width_p+1 ({write_not_read, addr})
//  fill_width_p   64   DMA data beat width
//  block_beats_p  8    beats per DMA burst (l2 block width / fill_width_p), >=1
//  tag_els_p      4    depth of each of the read and write tag FIFOs
// PORTS
//  clk_i              in   1                      clock
//  reset_i            in   1                      async active-high reset
//  dma_pkt_i          in   banks_p*pkt_w          per-bank DMA packet
//  dma_pkt_v_i        in   banks_p                per-bank pkt valid
//  dma_pkt_ready_and_o out banks_p                per-bank pkt ready
//  dma_data_i         in   banks_p*fill_width_p   per-bank write data
//  dma_data_v_i       in   banks_p                write data valid
//  dma_data_ready_and_o out banks_p               write data ready
//  dma_data_o         out  banks_p*fill_width_p   per-bank read data (shared bus fanned out)
//  dma_data_v_o       out  banks_p                read data valid
//  dma_data_ready_and_i in banks_p                read data ready
//  mem_pkt_o / _v_o / _ready_and_i   out/out/in   pkt_w/1/1   merged DMA packet
//  mem_wdata_o / _v_o / _ready_and_i out/out/in   fill_width_p/1/1  merged write data
//  mem_rdata_i / _v_i / _ready_and_o in/in/out    fill_width_p/1/1  merged read data
// BEHAVIOUR
//  - All handshakes ready-and-valid; transfer iff v&ready same cycle. No comb path from any
//    ready input to the same channel's valid output.
//  - Reset (async assert, sync-safe deassert): tag FIFOs empty, beat counters 0, RR pointer 0.
//    All v_o and ready_and_o are 0 during/after reset until the conditions below hold.
//  - Pkt arbitration: bank i eligible iff dma_pkt_v_i[i] and its tag FIFO (rd if
//    write_not_read=0, wr if 1) not full. mem_pkt_v_o = any eligible; winner = first eligible
//    at/after RR pointer; mem_pkt_o = winner's pkt unchanged; dma_pkt_ready_and_o[winner] =
//    mem_pkt_ready_and_i, others 0. On handshake: push winner id into chosen tag FIFO, RR
//    pointer <= winner+1 (mod banks_p). Full check is registered count (no same-cycle bypass).
//  - Write data: if wr FIFO non-empty, head id h selects dma_data_i[h]; mem_wdata_v_o =
//    dma_data_v_i[h]; dma_data_ready_and_o[h] = mem_wdata_ready_and_i; all other banks 0.
//    Each beat increments wr counter; beat block_beats_p-1 pops FIFO, counter <= 0. Empty FIFO:
//    v_o=0, all readies 0 (data never forwarded before its pkt is accepted).
//  - Read data: if rd FIFO non-empty, head h: dma_data_o[*] = mem_rdata_i, dma_data_v_o[h] =
//    mem_rdata_v_i, others 0; mem_rdata_ready_and_o = dma_data_ready_and_i[h]. Count/pop as
//    write. Empty: mem_rdata_ready_and_o=0.
//  - Pkt push and data pop on same FIFO same cycle: both happen, count unchanged.
//  - Latency: pkt 0 cycles (comb mux); data 0 cycles; counters wrap at block_beats_p.
//  - banks_p=1: arbiter degenerates to pass-through; id width = max(1,clog2(banks_p)).
//  - Reset mid-burst discards outstanding tags; memory side must be reset together.
//  - Assertions: mem_rdata_v_i with rd FIFO empty is an error (sim-only check).
// STRUCTURE
//  - Reuse bsg_cache_pkg dma pkt struct; add bank-id width localparam to bp_me_pkg only if
//    shared; otherwise local.
//  - Sub-module bp_l2_dma_burst_tracker: tag FIFO (bsg_fifo_1r1w_small) + beat counter,
//    ports push id/v, head id/v, beat_fire -> pop on last; instantiated twice (rd, wr).
//  - Arbiter: bsg_arb_round_robin driven by eligibility vector.
// TESTING
//  1 Bank0 read @0x1000, bank1 read @0x2000 same cycle -> pkts out 0x1000 then 0x2000; 16
//    read beats routed 8 to bank0 then 8 to bank1, in order.
//  2 Bank1 write @0x40 + 8 beats D0..D7, bank0 write queued -> mem_wdata D0..D7 of bank1 first;
//    bank0 data ready stays 0 until bank1 burst pops.
//  3 Fill rd FIFO (4 reads from bank0) with mem_rdata withheld -> 5th read pkt ready=0,
//    bank1 write still granted; release 1 burst -> 5th read accepted next cycle.
//  4 Random mem_pkt/mem_wdata/dma_data back-pressure 0-3 cycles, 1000 mixed ops -> scoreboard
//    matches every beat to issuing bank; RR fairness: no bank starved >banks_p grants.
//  5 Assert reset_i mid read burst (beat 3) -> all v/ready 0 asynchronously; after release
//    new read from bank1 gets pkt out and 8 beats correctly.
//  6 banks_p=1 build: pass-through read+write of one block each, zero added latency.

Source files
------------

// File: rtl/bp_l2_dma_mux_pkg.sv
// Shared types and helpers for the L2 DMA merge block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bp_l2_dma_mux_pkg;

  // Top bit of a DMA packet distinguishes a write burst from a read burst.
  typedef enum logic {
    DMA_READ  = 1'b0,
    DMA_WRITE = 1'b1
  } dma_op_e;

  // Index width that stays legal for a single-entry structure.
  function automatic int safe_clog2(input int n);
    if (n > 1) return $clog2(n);
    else       return 1;
  endfunction

endpackage

// File: rtl/bp_l2_dma_burst_tracker.sv
// In-order bank-id tag FIFO plus beat counter that retires one tag per full burst.
// Latency: pushed id becomes head the next cycle; pop happens on the last beat's fire.
// Backpressure: ready_o low when the tag FIFO is full (registered, no pop bypass).
module bp_l2_dma_burst_tracker
  import bp_l2_dma_mux_pkg::*;
#(
  parameter int id_width_p    = 1,
  parameter int els_p         = 4,
  parameter int block_beats_p = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [id_width_p-1:0] push_id_i,
  input  logic                  push_v_i,
  output logic                  ready_o,
  output logic [id_width_p-1:0] head_id_o,
  output logic                  head_v_o,
  input  logic                  beat_fire_i
);

  localparam int BW = safe_clog2(block_beats_p);

  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          last_beat;
  logic          pop;

  assign last_beat = (beat_cnt_q == BW'(block_beats_p - 1));
  assign pop       = beat_fire_i & last_beat & head_v_o;

  bp_l2_dma_mux_fifo #(
    .width_p (id_width_p),
    .els_p   (els_p)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (push_id_i),
    .v_i     (push_v_i),
    .ready_o (ready_o),
    .data_o  (head_id_o),
    .v_o     (head_v_o),
    .yumi_i  (pop)
  );

  // Beat counter wraps to zero on the final beat of each burst.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat_fire_i) beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
  end

  // Beat counter register; a reset mid-burst abandons the partial count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) beat_cnt_q <= '0;
    else         beat_cnt_q <= beat_cnt_d;
  end

endmodule

// File: rtl/bp_l2_dma_mux_fifo.sv
// Small generic 1-read/1-write FIFO with registered occupancy count.
// Latency: one cycle from push to head visible; pop is combinational on yumi.
// Backpressure: ready_o drops when full; a pop in the same cycle does not free a slot.
module bp_l2_dma_mux_fifo
  import bp_l2_dma_mux_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int PW = safe_clog2(els_p);
  localparam int CW = $clog2(els_p + 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               push, pop;

  assign ready_o = (cnt_q != CW'(els_p));
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  // Next pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = (wptr_q == PW'(els_p - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PW'(els_p - 1)) ? '0 : rptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Control state: pointers and count, cleared by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array needs no reset; the count guards every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_l2_dma_mux.sv
// Merges banks_p L2 DMA channels onto one memory-side DMA channel (RR pkt arbitration).
// Latency: zero cycles on pkt, write-data and read-data paths (combinational steering).
// Backpressure: ready/valid throughout; pkts stall when the target tag FIFO is full.
module bp_l2_dma_mux
  import bp_l2_dma_mux_pkg::*;
#(
  parameter int banks_p       = 2,
  parameter int daddr_width_p = 32,
  parameter int fill_width_p  = 64,
  parameter int block_beats_p = 8,
  parameter int tag_els_p     = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [banks_p*(daddr_width_p+1)-1:0]     dma_pkt_i,
  input  logic [banks_p-1:0]                       dma_pkt_v_i,
  output logic [banks_p-1:0]                       dma_pkt_ready_and_o,
  input  logic [banks_p*fill_width_p-1:0]          dma_data_i,
  input  logic [banks_p-1:0]                       dma_data_v_i,
  output logic [banks_p-1:0]                       dma_data_ready_and_o,
  output logic [banks_p*fill_width_p-1:0]          dma_data_o,
  output logic [banks_p-1:0]                       dma_data_v_o,
  input  logic [banks_p-1:0]                       dma_data_ready_and_i,
  output logic [daddr_width_p:0]                   mem_pkt_o,
  output logic                                     mem_pkt_v_o,
  input  logic                                     mem_pkt_ready_and_i,
  output logic [fill_width_p-1:0]                  mem_wdata_o,
  output logic                                     mem_wdata_v_o,
  input  logic                                     mem_wdata_ready_and_i,
  input  logic [fill_width_p-1:0]                  mem_rdata_i,
  input  logic                                     mem_rdata_v_i,
  output logic                                     mem_rdata_ready_and_o
);

  localparam int PKT_W = daddr_width_p + 1;
  localparam int ID_W  = safe_clog2(banks_p);

  logic [PKT_W-1:0]        pkt_arr   [banks_p];
  logic [fill_width_p-1:0] wdata_arr [banks_p];

  logic [banks_p-1:0] elig;
  logic               any_elig;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               pkt_fire;
  logic               win_is_wr;

  logic               rd_ready, wr_ready;
  logic               rd_head_v, wr_head_v;
  logic [ID_W-1:0]    rd_head, wr_head;
  logic               rd_fire, wr_fire;

  for (genvar g = 0; g < banks_p; g++) begin : g_unpack
    assign pkt_arr[g]   = dma_pkt_i[g*PKT_W +: PKT_W];
    assign wdata_arr[g] = dma_data_i[g*fill_width_p +: fill_width_p];
    assign dma_data_o[g*fill_width_p +: fill_width_p] = mem_rdata_i;
  end

  // A bank competes only if the tag FIFO its packet would occupy has room.
  always_comb begin
    elig = '0;
    for (int i = 0; i < banks_p; i++) begin
      if (dma_op_e'(pkt_arr[i][PKT_W-1]) == DMA_WRITE) elig[i] = dma_pkt_v_i[i] & wr_ready;
      else                                             elig[i] = dma_pkt_v_i[i] & rd_ready;
    end
  end

  // Round-robin pick: first eligible bank at or after the pointer.
  always_comb begin
    int idx;
    idx      = 0;
    winner   = '0;
    any_elig = 1'b0;
    for (int k = 0; k < banks_p; k++) begin
      idx = (int'(rr_ptr_q) + k) % banks_p;
      if (!any_elig && elig[idx]) begin
        winner   = ID_W'(idx);
        any_elig = 1'b1;
      end
    end
  end

  // Packet path: mux the winner through; valid is held low while in reset.
  always_comb begin
    mem_pkt_v_o         = any_elig & ~reset_i;
    mem_pkt_o           = pkt_arr[winner];
    dma_pkt_ready_and_o = '0;
    for (int i = 0; i < banks_p; i++) begin
      dma_pkt_ready_and_o[i] = mem_pkt_v_o & mem_pkt_ready_and_i & (winner == ID_W'(i));
    end
  end

  assign pkt_fire  = mem_pkt_v_o & mem_pkt_ready_and_i;
  assign win_is_wr = (dma_op_e'(pkt_arr[winner][PKT_W-1]) == DMA_WRITE);

  // Pointer advances past the winner only when its packet actually transfers.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pkt_fire) rr_ptr_d = (winner == ID_W'(banks_p - 1)) ? '0 : winner + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  bp_l2_dma_burst_tracker #(
    .id_width_p    (ID_W),
    .els_p         (tag_els_p),
    .block_beats_p (block_beats_p)
  ) u_rd_tracker (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_id_i   (winner),
    .push_v_i    (pkt_fire & ~win_is_wr),
    .ready_o     (rd_ready),
    .head_id_o   (rd_head),
    .head_v_o    (rd_head_v),
    .beat_fire_i (rd_fire)
  );

  bp_l2_dma_burst_tracker #(
    .id_width_p    (ID_W),
    .els_p         (tag_els_p),
    .block_beats_p (block_beats_p)
  ) u_wr_tracker (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_id_i   (winner),
    .push_v_i    (pkt_fire & win_is_wr),
    .ready_o     (wr_ready),
    .head_id_o   (wr_head),
    .head_v_o    (wr_head_v),
    .beat_fire_i (wr_fire)
  );

  // Write data: only the bank owning the oldest outstanding write burst is connected.
  always_comb begin
    mem_wdata_o          = wdata_arr[wr_head];
    mem_wdata_v_o        = wr_head_v & dma_data_v_i[wr_head];
    dma_data_ready_and_o = '0;
    for (int i = 0; i < banks_p; i++) begin
      dma_data_ready_and_o[i] = wr_head_v & mem_wdata_ready_and_i & (wr_head == ID_W'(i));
    end
  end

  assign wr_fire = mem_wdata_v_o & mem_wdata_ready_and_i;

  // Read data: shared bus fans out; valid steered to the oldest outstanding read bank.
  always_comb begin
    mem_rdata_ready_and_o = rd_head_v & dma_data_ready_and_i[rd_head];
    dma_data_v_o          = '0;
    for (int i = 0; i < banks_p; i++) begin
      dma_data_v_o[i] = rd_head_v & mem_rdata_v_i & (rd_head == ID_W'(i));
    end
  end

  assign rd_fire = mem_rdata_v_i & mem_rdata_ready_and_o;

  // Memory must never return read data that no accepted read packet asked for.
  rd_no_orphan_beat: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_rdata_v_i |-> rd_head_v);

endmodule
